// File: rtl/fetch_aligner_pkg.sv
// Shared RISC-V fetch definitions: reset PC default, RVC quadrant decode,
// and the fetch FSM state encoding.
package fetch_aligner_pkg;

    localparam int unsigned XLEN = 32;

    // Default first PC after reset.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    // Low two bits of a halfword equal to this mark a 32-bit instruction.
    localparam logic [1:0] RVC_QUADRANT_32 = 2'b11;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fa_state_e;

    // True when the halfword starts a 16-bit (compressed) instruction.
    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != RVC_QUADRANT_32;
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: reads word-organised IMem and hands one aligned
// RV32I/RV32C instruction per handshake to decode, stitching 32-bit
// instructions that straddle a word boundary and handling PC redirects.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr           word-aligned byte address to IMem
//   imem_rdata          IMem word at imem_addr (same cycle)
//   redirect_valid/pc   load a new PC (bit 0 ignored)
//   out_valid/ready     decode handshake
//   out_instr           instruction (compressed ones zero-extended)
//   out_pc              PC of out_instr
//   out_is_compressed   out_instr is a 16-bit instruction
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_is_compressed
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] HALF_MASK = ~ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STEP_HALF = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] STEP_WORD = ADDR_WIDTH'(4);

    fa_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           hbuf_q, hbuf_d;
    logic                  hbuf_valid_q, hbuf_valid_d;

    logic                  valid_c;
    logic [INST_WIDTH-1:0] instr_c;
    logic                  comp_c;
    logic [15:0]           half_lo;
    logic [15:0]           half_hi;

    assign half_lo = imem_rdata[15:0];
    assign half_hi = imem_rdata[31:16];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            fetch_addr_q <= RESET_PC & WORD_MASK;
            pc_q         <= RESET_PC;
            hbuf_q       <= '0;
            hbuf_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            hbuf_q       <= hbuf_d;
            hbuf_valid_q <= hbuf_valid_d;
        end
    end

    // Next-state and emitted instruction selection.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        hbuf_d       = hbuf_q;
        hbuf_valid_d = hbuf_valid_q;
        valid_c      = 1'b0;
        instr_c      = '0;
        comp_c       = 1'b0;

        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (hbuf_valid_q) begin
            if (is_rvc(hbuf_q)) begin
                // Leftover halfword is a whole compressed instruction.
                valid_c = 1'b1;
                instr_c = INST_WIDTH'(hbuf_q);
                comp_c  = 1'b1;
                if (out_ready) begin
                    pc_d         = pc_q + STEP_HALF;
                    hbuf_valid_d = 1'b0;
                end
            end else begin
                // Leftover is the low half of a 32-bit instruction.
                valid_c = 1'b1;
                instr_c = INST_WIDTH'({half_lo, hbuf_q});
                if (out_ready) begin
                    pc_d         = pc_q + STEP_WORD;
                    hbuf_d       = half_hi;
                    fetch_addr_d = fetch_addr_q + STEP_WORD;
                end
            end
        end else if (!pc_q[1]) begin
            if (is_rvc(half_lo)) begin
                valid_c = 1'b1;
                instr_c = INST_WIDTH'(half_lo);
                comp_c  = 1'b1;
                if (out_ready) begin
                    pc_d         = pc_q + STEP_HALF;
                    hbuf_d       = half_hi;
                    hbuf_valid_d = 1'b1;
                    fetch_addr_d = fetch_addr_q + STEP_WORD;
                end
            end else begin
                valid_c = 1'b1;
                instr_c = imem_rdata;
                if (out_ready) begin
                    pc_d         = pc_q + STEP_WORD;
                    fetch_addr_d = fetch_addr_q + STEP_WORD;
                end
            end
        end else begin
            if (is_rvc(half_hi)) begin
                valid_c = 1'b1;
                instr_c = INST_WIDTH'(half_hi);
                comp_c  = 1'b1;
                if (out_ready) begin
                    pc_d         = pc_q + STEP_HALF;
                    fetch_addr_d = fetch_addr_q + STEP_WORD;
                end
            end else begin
                // Split: park the upper half and fetch the next word; bubble.
                hbuf_d       = half_hi;
                hbuf_valid_d = 1'b1;
                fetch_addr_d = fetch_addr_q + STEP_WORD;
            end
        end

        // Redirect wins over everything, squashing any offered instruction.
        if (redirect_valid) begin
            valid_c      = 1'b0;
            instr_c      = '0;
            comp_c       = 1'b0;
            pc_d         = redirect_pc & HALF_MASK;
            fetch_addr_d = redirect_pc & WORD_MASK;
            hbuf_valid_d = 1'b0;
            state_d      = ST_RUN;
        end
    end

    assign imem_addr         = fetch_addr_q;
    assign out_valid         = valid_c;
    assign out_instr         = instr_c;
    assign out_pc            = pc_q;
    assign out_is_compressed = comp_c;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner with a behavioural IMem and a scoreboard
// queue of expected instructions popped on each handshake.
module tb_fetch_aligner;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_compressed;

    logic [31:0] mem [256];
    exp_t        exp_q [$];
    int          total;
    int          bad;

    fetch_aligner dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .out_is_compressed(out_is_compressed)
    );

    assign imem_rdata = mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        exp_q.push_back(e);
    endtask

    // Score any handshake happening this cycle, then advance one clock.
    task automatic clk_step();
        exp_t e;
        if (out_valid && out_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out observed pc=0x%08h instr=0x%08h expected=none",
                       out_pc, out_instr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_pc", out_pc, e.pc);
                check("out_is_compressed", 32'(out_is_compressed), 32'(e.comp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
        check("redirect_squash", 32'(out_valid), 32'd0);
        clk_step();
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic drain_check(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset and two compressed instructions from RESET_PC.
        mem[0] = 32'h0086_0091;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_comp", 32'(out_is_compressed), 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        check("boot_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("first_valid", 32'(out_valid), 32'd1);
        check("a_imem_addr0", imem_addr, 32'd0);
        out_ready = 1'b1;
        push(32'h0000_0091, 32'd0, 1'b1);
        push(32'h0000_0086, 32'd2, 1'b1);
        clk_step();
        check("a_imem_addr4", imem_addr, 32'd4);
        clk_step();
        out_ready = 1'b0;
        drain_check("a_drain");

        // 32-bit instruction straddling a word boundary.
        mem[0] = 32'h0193_0091;
        mem[1] = 32'h0086_0070;
        do_redirect(32'h0);
        out_ready = 1'b1;
        push(32'h0000_0091, 32'd0, 1'b1);
        push(32'h0070_0193, 32'd2, 1'b0);
        push(32'h0000_0086, 32'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("b_back_to_back", 32'(out_valid), 32'd1);
            clk_step();
        end
        out_ready = 1'b0;
        drain_check("b_drain");

        // Plain 32-bit stream.
        mem[0] = 32'h0070_0193;
        mem[1] = 32'h0231_60B3;
        mem[2] = 32'h0086_0070;
        do_redirect(32'h0);
        out_ready = 1'b1;
        push(32'h0070_0193, 32'd0, 1'b0);
        push(32'h0231_60B3, 32'd4, 1'b0);
        check("c_imem_addr0", imem_addr, 32'd0);
        clk_step();
        check("c_imem_addr4", imem_addr, 32'd4);
        clk_step();
        check("c_imem_addr8", imem_addr, 32'd8);
        out_ready = 1'b0;
        drain_check("c_drain");

        // Redirect to an odd halfword holding a 32-bit instruction.
        mem[1] = 32'h0193_1111;
        out_ready = 1'b1;
        #1;
        check("d_offered", 32'(out_valid), 32'd1);
        do_redirect(32'h6);
        check("d_split_bubble", 32'(out_valid), 32'd0);
        check("d_split_instr", out_instr, 32'd0);
        clk_step();
        push(32'h0070_0193, 32'd6, 1'b0);
        check("d_after_split", 32'(out_valid), 32'd1);
        clk_step();
        out_ready = 1'b0;
        drain_check("d_drain");

        // Backpressure: three stalled cycles with stable outputs.
        for (int i = 0; i < 3; i++) begin
            check("e_stall_valid", 32'(out_valid), 32'd1);
            check("e_stall_instr", out_instr, 32'h0000_0086);
            check("e_stall_pc", out_pc, 32'd10);
            check("e_stall_comp", 32'(out_is_compressed), 32'd1);
            check("e_stall_addr", imem_addr, 32'd12);
            clk_step();
        end
        out_ready = 1'b1;
        push(32'h0000_0086, 32'd10, 1'b1);
        clk_step();
        out_ready = 1'b0;
        // Redirect during a stall; bit 0 of the target is dropped.
        do_redirect(32'h9);
        check("e_redir_pc", out_pc, 32'd8);
        check("e_redir_instr", out_instr, 32'h0000_0070);
        out_ready = 1'b1;
        push(32'h0000_0070, 32'd8, 1'b1);
        push(32'h0000_0086, 32'd10, 1'b1);
        clk_step();
        clk_step();
        out_ready = 1'b0;
        drain_check("e_drain");

        // Address wrap at the top of the address space.
        mem[255] = 32'h0193_0091;
        mem[0]   = 32'h0086_0070;
        do_redirect(32'hFFFF_FFFC);
        check("g_imem_top", imem_addr, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        push(32'h0000_0091, 32'hFFFF_FFFC, 1'b1);
        push(32'h0070_0193, 32'hFFFF_FFFE, 1'b0);
        push(32'h0000_0086, 32'd2, 1'b1);
        clk_step();
        check("g_imem_wrap", imem_addr, 32'd0);
        clk_step();
        clk_step();
        out_ready = 1'b0;
        drain_check("g_drain");

        // Reset mid-stream while a leftover halfword is buffered.
        mem[0] = 32'h0086_0091;
        do_redirect(32'h0);
        out_ready = 1'b1;
        push(32'h0000_0091, 32'd0, 1'b1);
        clk_step();
        out_ready = 1'b0;
        check("f_pre_pc", out_pc, 32'd2);
        rst_n = 1'b0;
        #1;
        check("f_rst_valid", 32'(out_valid), 32'd0);
        check("f_rst_pc", out_pc, 32'd0);
        check("f_rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        check("f_boot_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("f_restart_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        push(32'h0000_0091, 32'd0, 1'b1);
        push(32'h0000_0086, 32'd2, 1'b1);
        clk_step();
        clk_step();
        out_ready = 1'b0;
        drain_check("f_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
